// File: rtl/serial_shift_tx_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
// FSM encodings and line levels live here so both ends agree.
package serial_shift_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled.
// tick pulses for one cycle on the terminal count.
module bit_tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == LAST);
  assign tick   = en && w_term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_term ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_shift_tx.sv
// Parallel-in / serial-out transmitter: start bit, DATA_W data bits,
// stop bit, each lasting CLK_DIV clocks, loaded over valid/ready.
import serial_shift_tx_pkg::*;

module serial_shift_tx #(
  parameter int CLK_DIV   = 1000,
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_sh;
  logic [IW-1:0]     r_idx;
  logic              r_tx;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_tick;
  logic              w_idle;
  logic              w_bit;
  logic [DATA_W-1:0] w_shift;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_bit   = LSB_FIRST ? r_sh[0] : r_sh[DATA_W-1];
  assign w_shift = LSB_FIRST ? (r_sh >> 1) : (r_sh << 1);

  bit_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(w_idle),
    .en   (!w_idle),
    .tick (w_tick)
  );

  // tx always carries the current shift-reg bit; the shift happens as it loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sh    <= '0;
      r_idx   <= '0;
      r_tx    <= LINE_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (din_valid && r_ready) begin
            r_sh    <= din;
            r_idx   <= '0;
            r_tx    <= LINE_START;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= w_bit;
            r_sh    <= w_shift;
            r_idx   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_idx == LAST_IDX) begin
              r_tx    <= LINE_STOP;
              r_state <= ST_STOP;
            end else begin
              r_tx  <= w_bit;
              r_sh  <= w_shift;
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_tx    <= LINE_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign din_ready = r_ready;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_serial_shift_tx.sv
// Directed bench for serial_shift_tx: three instances cover LSB-first,
// MSB-first and the minimal CLK_DIV=2 / DATA_W=1 configuration.
module tb_serial_shift_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       rst0, rst1, rst2;
  logic [7:0] din0, din1;
  logic [0:0] din2;
  logic       v0, v1, v2;
  logic       rdy0, rdy1, rdy2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  serial_shift_tx #(.CLK_DIV(4), .DATA_W(8), .LSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst0), .din(din0), .din_valid(v0),
    .din_ready(rdy0), .tx(tx0), .busy(busy0), .done(done0)
  );

  serial_shift_tx #(.CLK_DIV(4), .DATA_W(8), .LSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst1), .din(din1), .din_valid(v1),
    .din_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
  );

  serial_shift_tx #(.CLK_DIV(2), .DATA_W(1), .LSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst(rst2), .din(din2), .din_valid(v2),
    .din_ready(rdy2), .tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge right after the accept edge of u0.
  task automatic frame0(input logic [9:0] pat, input string tag);
    for (int i = 0; i < 40; i++) begin
      chk({tag, "_tx"}, 16'(tx0), 16'(pat[i/4]));
      chk({tag, "_busy"}, 16'(busy0), 16'd1);
      chk({tag, "_rdy"}, 16'(rdy0), 16'd0);
      chk({tag, "_done"}, 16'(done0), 16'd0);
      @(negedge clk);
    end
    chk({tag, "_done_end"}, 16'(done0), 16'd1);
    chk({tag, "_rdy_end"}, 16'(rdy0), 16'd1);
    chk({tag, "_busy_end"}, 16'(busy0), 16'd0);
    chk({tag, "_tx_end"}, 16'(tx0), 16'd1);
  endtask

  logic [9:0] pat;
  logic [5:0] pat6;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    din0 = '0; din1 = '0; din2 = '0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 16'(tx0), 16'd1);
    chk("rst_rdy", 16'(rdy0), 16'd1);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // 1: idle with no request
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_tx", 16'(tx0), 16'd1);
      chk("idle_rdy", 16'(rdy0), 16'd1);
      chk("idle_busy", 16'(busy0), 16'd0);
      chk("idle_done", 16'(done0), 16'd0);
    end

    // 2: 0xA5 LSB first
    din0 = 8'hA5; v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    pat = 10'b1101001010;
    frame0(pat, "a5");
    @(negedge clk);
    chk("a5_done_once", 16'(done0), 16'd0);
    chk("a5_idle_tx", 16'(tx0), 16'd1);

    // 3: 0x81 MSB first, din disturbed mid-frame
    din1 = 8'h81; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    pat = 10'b1100000010;
    for (int i = 0; i < 40; i++) begin
      if (i == 12) begin din1 = 8'hFF; v1 = 1'b1; end
      if (i == 20) v1 = 1'b0;
      chk("m81_tx", 16'(tx1), 16'(pat[i/4]));
      chk("m81_rdy", 16'(rdy1), 16'd0);
      chk("m81_done", 16'(done1), 16'd0);
      @(negedge clk);
    end
    chk("m81_done_end", 16'(done1), 16'd1);
    chk("m81_tx_end", 16'(tx1), 16'd1);

    // 4: back-to-back with valid held high
    @(negedge clk);
    din0 = 8'h3C; v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din0 = 8'hC3;
    pat = 10'b1001111000;
    frame0(pat, "b2b1");
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    pat = 10'b1110000110;
    frame0(pat, "b2b2");
    @(negedge clk);
    chk("b2b_idle_rdy", 16'(rdy0), 16'd1);
    chk("b2b_idle_tx", 16'(tx0), 16'd1);

    // 5: async reset mid-frame, then a clean frame
    din0 = 8'h77; v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    repeat (16) @(negedge clk);
    chk("abort_busy_pre", 16'(busy0), 16'd1);
    #2 rst0 = 1'b1;
    #1;
    chk("abort_tx", 16'(tx0), 16'd1);
    chk("abort_busy", 16'(busy0), 16'd0);
    chk("abort_rdy", 16'(rdy0), 16'd1);
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    chk("abort_idle_tx", 16'(tx0), 16'd1);
    din0 = 8'h5A; v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    pat = 10'b1010110100;
    frame0(pat, "r5a");

    // 6: minimal configuration
    din2 = 1'b1; v2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    pat6 = 6'b111100;
    for (int i = 0; i < 6; i++) begin
      chk("min_tx", 16'(tx2), 16'(pat6[i]));
      chk("min_done", 16'(done2), 16'd0);
      chk("min_busy", 16'(busy2), 16'd1);
      @(negedge clk);
    end
    chk("min_done_end", 16'(done2), 16'd1);
    chk("min_rdy_end", 16'(rdy2), 16'd1);
    chk("min_tx_end", 16'(tx2), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
